// File: rtl/vga_out_pkg.sv
// Shared types and helpers for the VGA output stage: colour mode encoding,
// default widths and the bit-replicating colour expansion function.
package vga_out_pkg;

    typedef enum logic [1:0] {
        MODE_RGB    = 2'd0,
        MODE_MONO_G = 2'd1,
        MODE_MONO_W = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    localparam int DEF_IN_W = 1;
    localparam int DEF_R_W  = 5;
    localparam int DEF_G_W  = 6;
    localparam int DEF_B_W  = 5;
    localparam int DEF_PIPE = 2;

    // Widest operands the expansion function handles.
    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_W = 16;
    localparam int IN_IDX_W  = $clog2(MAX_IN_W);
    localparam int OUT_IDX_W = $clog2(MAX_OUT_W);

    // Repeat the in_w-bit value MSB-first until out_w bits are filled. When
    // in_w > out_w this naturally keeps the input MSBs. Result is right-aligned;
    // the caller truncates to its channel width.
    function automatic logic [MAX_OUT_W-1:0] expand(input logic [MAX_IN_W-1:0] val,
                                                    input int in_w,
                                                    input int out_w);
        logic [MAX_OUT_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            if (i < out_w)
                res[OUT_IDX_W'(out_w - 1 - i)] = val[IN_IDX_W'(in_w - 1 - (i % in_w))];
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous, loadable reset value.
module vga_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk25,
    input  logic         rst,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Next state: new sample enters stage 0, everything else moves one stage on.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++)
            stage_d[i] = stage_q[i-1];
    end

    // Stage registers; every stage is cleared so reset flushes in-flight pixels.
    always_ff @(posedge clk25) begin
        // NOTE: clocked state uses non-blocking (<=) so all stages shift on the
        // old values; blocking here would collapse the chain into one register.
        if (rst) begin
            // NOTE: this storage is reset (unlike a typical RAM) because its
            // contents drive the pins directly and must show idle syncs at once.
            for (int i = 0; i < DEPTH; i++)
                stage_q[i] <= rst_val;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                stage_q[i] <= stage_d[i];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_out_stage.sv
// VGA output stage: colour expansion, mode/scanline processing latched per
// frame, sync edge tracking, frame heartbeat and a PIPE-deep output delay.
module vga_out_stage
    import vga_out_pkg::*;
#(
    parameter int IN_W         = DEF_IN_W,
    parameter int R_W          = DEF_R_W,
    parameter int G_W          = DEF_G_W,
    parameter int B_W          = DEF_B_W,
    parameter int PIPE         = DEF_PIPE,
    parameter bit SYNC_ACT_LOW = 1'b1,
    parameter int HB_FRAMES    = 30
) (
    input  logic            clk25,
    input  logic            rst,
    input  logic [IN_W-1:0] r_in,
    input  logic [IN_W-1:0] g_in,
    input  logic [IN_W-1:0] b_in,
    input  logic            hs_in,
    input  logic            vs_in,
    input  logic [1:0]      mode,
    input  logic            scan_en,
    output logic [R_W-1:0]  vga_r,
    output logic [G_W-1:0]  vga_g,
    output logic [B_W-1:0]  vga_b,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            led_hb
);

    localparam logic SYNC_IDLE = SYNC_ACT_LOW ? 1'b1 : 1'b0;
    localparam logic SYNC_ACT  = ~SYNC_IDLE;
    localparam int   CNT_W     = (HB_FRAMES > 1) ? $clog2(HB_FRAMES) : 1;
    localparam int   DW        = 2 + R_W + G_W + B_W;
    localparam logic [DW-1:0] PIPE_RST = {SYNC_IDLE, SYNC_IDLE, {(R_W+G_W+B_W){1'b0}}};

    logic             hs_prev_q, hs_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic             parity_q, parity_d;
    mode_e            mode_eff_q, mode_eff_d;
    logic             scan_eff_q, scan_eff_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             led_hb_q, led_hb_d;

    logic             hs_edge, vs_edge;
    logic             pix_on, dim;
    logic [R_W-1:0]   r_exp, r_sel;
    logic [G_W-1:0]   g_exp, g_sel;
    logic [B_W-1:0]   b_exp, b_sel;
    logic [DW-1:0]    pipe_in, pipe_out;

    assign r_exp = R_W'(expand(MAX_IN_W'(r_in), IN_W, R_W));
    assign g_exp = G_W'(expand(MAX_IN_W'(g_in), IN_W, G_W));
    assign b_exp = B_W'(expand(MAX_IN_W'(b_in), IN_W, B_W));

    // Edge detection, line parity, per-frame latching and heartbeat counter.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        hs_prev_d   = hs_in;
        vs_prev_d   = vs_in;
        parity_d    = parity_q;
        mode_eff_d  = mode_eff_q;
        scan_eff_d  = scan_eff_q;
        frame_cnt_d = frame_cnt_q;
        led_hb_d    = led_hb_q;

        hs_edge = (hs_in == SYNC_ACT) && (hs_prev_q != SYNC_ACT);
        vs_edge = (vs_in == SYNC_ACT) && (vs_prev_q != SYNC_ACT);

        // A frame start overrides a coincident line start: new frames begin even.
        if (vs_edge)
            parity_d = 1'b0;
        else if (hs_edge)
            parity_d = ~parity_q;

        if (vs_edge) begin
            mode_eff_d = mode_e'(mode);
            scan_eff_d = scan_en;
            if (frame_cnt_q == CNT_W'(HB_FRAMES - 1)) begin
                frame_cnt_d = '0;
                led_hb_d    = ~led_hb_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Colour selection by the latched mode, then optional scanline halving.
    always_comb begin
        r_sel  = '0;
        g_sel  = '0;
        b_sel  = '0;
        pix_on = r_in[IN_W-1] | g_in[IN_W-1] | b_in[IN_W-1];
        dim    = scan_eff_q & parity_q;

        unique case (mode_eff_q)
            MODE_RGB: begin
                r_sel = r_exp;
                g_sel = g_exp;
                b_sel = b_exp;
            end
            MODE_MONO_G: begin
                g_sel = {G_W{pix_on}};
            end
            MODE_MONO_W: begin
                r_sel = {R_W{pix_on}};
                g_sel = {G_W{pix_on}};
                b_sel = {B_W{pix_on}};
            end
            MODE_BLANK: ;
        endcase

        if (dim) begin
            r_sel = r_sel >> 1;
            g_sel = g_sel >> 1;
            b_sel = b_sel >> 1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk25) begin
        if (rst) begin
            hs_prev_q   <= SYNC_IDLE;
            vs_prev_q   <= SYNC_IDLE;
            parity_q    <= 1'b0;
            mode_eff_q  <= MODE_RGB;
            scan_eff_q  <= 1'b0;
            frame_cnt_q <= '0;
            led_hb_q    <= 1'b0;
        end else begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            parity_q    <= parity_d;
            mode_eff_q  <= mode_eff_d;
            scan_eff_q  <= scan_eff_d;
            frame_cnt_q <= frame_cnt_d;
            led_hb_q    <= led_hb_d;
        end
    end

    assign pipe_in = {hs_in, vs_in, r_sel, g_sel, b_sel};

    vga_delay_line #(
        .W     (DW),
        .DEPTH (PIPE)
    ) u_delay (
        .clk25   (clk25),
        .rst     (rst),
        .rst_val (PIPE_RST),
        .din     (pipe_in),
        .dout    (pipe_out)
    );

    assign {vga_hs, vga_vs, vga_r, vga_g, vga_b} = pipe_out;
    assign led_hb = led_hb_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Self-checking bench for vga_out_stage: table of per-cycle stimulus with
// expected colour, scoreboard queue aligned to the pipeline latency, plus
// hand-written reset, wide-input and heartbeat sequences.
module tb_vga_out_stage;

    localparam int PIPE = 2;
    localparam logic [4:0] F5 = 5'h1f;
    localparam logic [5:0] F6 = 6'h3f;
    localparam logic [4:0] H5 = 5'h0f;
    localparam logic [5:0] H6 = 6'h1f;

    typedef struct {
        logic [2:0] rgb;
        logic       hs, vs;
        logic [1:0] mode;
        logic       scan;
        logic [4:0] er;
        logic [5:0] eg;
        logic [4:0] eb;
    } vec_t;

    typedef struct {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        logic       hs, vs;
    } exp_t;

    logic       clk25 = 1'b0;
    logic       rst;
    logic [0:0] r_in, g_in, b_in;
    logic [1:0] r2, g2, b2;
    logic       hs_in, vs_in, scan_en;
    logic [1:0] mode;
    logic [4:0] vga_r, vga_b, vga_r2, vga_b2;
    logic [5:0] vga_g, vga_g2;
    logic       vga_hs, vga_vs, led_hb;
    logic       vga_hs2, vga_vs2, led_hb2;

    int total = 0;
    int bad   = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    always #20 clk25 = ~clk25;

    vga_out_stage dut (
        .clk25(clk25), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .mode(mode), .scan_en(scan_en),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .led_hb(led_hb)
    );

    vga_out_stage #(.IN_W(2)) dut2 (
        .clk25(clk25), .rst(rst), .r_in(r2), .g_in(g2), .b_in(b2),
        .hs_in(hs_in), .vs_in(vs_in), .mode(mode), .scan_en(scan_en),
        .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2),
        .vga_hs(vga_hs2), .vga_vs(vga_vs2), .led_hb(led_hb2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] rgb, input logic hs, input logic vs,
                                input logic [1:0] m, input logic s,
                                input logic [4:0] er, input logic [5:0] eg, input logic [4:0] eb);
        vec_t v;
        v.rgb = rgb; v.hs = hs; v.vs = vs; v.mode = m; v.scan = s;
        v.er = er; v.eg = eg; v.eb = eb;
        return v;
    endfunction

    // Compare the oldest pending expectation once the pipe is full, then drive
    // this cycle's inputs and queue what they must produce PIPE cycles later.
    task automatic drive_row(input vec_t v, input string name);
        exp_t e;
        if (sb_q.size() == PIPE) begin
            e = sb_q.pop_front();
            check(name, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, {e.r, e.g, e.b, e.hs, e.vs});
        end
        {r_in, g_in, b_in} = v.rgb;
        hs_in   = v.hs;
        vs_in   = v.vs;
        mode    = v.mode;
        scan_en = v.scan;
        e.r = v.er; e.g = v.eg; e.b = v.eb; e.hs = v.hs; e.vs = v.vs;
        sb_q.push_back(e);
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk25);
        drive_row(v, name);
    endtask

    initial begin
        // rgb, hs, vs, mode, scan, expected r/g/b
        // RGB mode, plain expansion, hs pulse passes through
        vecs.push_back(mk(3'b101, 1, 1, 0, 0, F5, 0,  F5));
        vecs.push_back(mk(3'b101, 1, 1, 0, 0, F5, 0,  F5));
        vecs.push_back(mk(3'b010, 1, 1, 0, 0, 0,  F6, 0));
        vecs.push_back(mk(3'b111, 0, 1, 0, 0, F5, F6, F5));
        vecs.push_back(mk(3'b000, 0, 1, 0, 0, 0,  0,  0));
        vecs.push_back(mk(3'b100, 1, 1, 0, 0, F5, 0,  0));
        // mode 1 requested mid-frame: no effect until the vs edge has passed
        vecs.push_back(mk(3'b100, 1, 1, 1, 0, F5, 0,  0));
        vecs.push_back(mk(3'b001, 1, 1, 1, 0, 0,  0,  F5));
        vecs.push_back(mk(3'b100, 1, 0, 1, 0, F5, 0,  0));
        vecs.push_back(mk(3'b100, 1, 0, 1, 0, 0,  F6, 0));
        vecs.push_back(mk(3'b000, 1, 1, 1, 0, 0,  0,  0));
        vecs.push_back(mk(3'b001, 1, 1, 2, 0, 0,  F6, 0));
        vecs.push_back(mk(3'b111, 1, 1, 2, 1, 0,  F6, 0));
        vecs.push_back(mk(3'b111, 1, 0, 2, 1, 0,  F6, 0));
        // mode 2 with scanlines: even lines full, odd lines halved
        vecs.push_back(mk(3'b111, 1, 1, 2, 1, F5, F6, F5));
        vecs.push_back(mk(3'b111, 0, 1, 2, 1, F5, F6, F5));
        vecs.push_back(mk(3'b111, 0, 1, 2, 1, H5, H6, H5));
        vecs.push_back(mk(3'b010, 1, 1, 2, 0, H5, H6, H5));
        vecs.push_back(mk(3'b000, 1, 1, 2, 0, 0,  0,  0));
        vecs.push_back(mk(3'b100, 0, 1, 2, 0, H5, H6, H5));
        vecs.push_back(mk(3'b100, 1, 1, 2, 0, F5, F6, F5));
        vecs.push_back(mk(3'b001, 0, 1, 2, 0, F5, F6, F5));
        vecs.push_back(mk(3'b001, 1, 1, 2, 0, H5, H6, H5));
        // hs and vs together: vs wins, next line even
        vecs.push_back(mk(3'b111, 0, 0, 2, 1, H5, H6, H5));
        vecs.push_back(mk(3'b111, 1, 1, 2, 1, F5, F6, F5));
        vecs.push_back(mk(3'b111, 0, 1, 2, 1, F5, F6, F5));
        vecs.push_back(mk(3'b111, 1, 1, 2, 1, H5, H6, H5));
        // blank mode latched; syncs still pass
        vecs.push_back(mk(3'b111, 1, 0, 3, 0, H5, H6, H5));
        vecs.push_back(mk(3'b111, 1, 1, 3, 0, 0,  0,  0));
        vecs.push_back(mk(3'b101, 0, 1, 3, 0, 0,  0,  0));
        vecs.push_back(mk(3'b000, 1, 1, 3, 0, 0,  0,  0));
        vecs.push_back(mk(3'b000, 1, 1, 3, 0, 0,  0,  0));

        rst = 1'b1;
        {r_in, g_in, b_in} = 3'b000;
        r2 = 2'b10; g2 = 2'b01; b2 = 2'b11;
        hs_in = 1'b1; vs_in = 1'b1; mode = 2'd0; scan_en = 1'b0;

        repeat (3) @(negedge clk25);
        check("reset_out", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, 32'h3);
        check("reset_led", {31'd0, led_hb}, 32'd0);
        rst = 1'b0;
        drive_row(vecs[0], "row0");
        for (int i = 1; i < vecs.size(); i++)
            step(vecs[i], $sformatf("row%0d", i));

        // One-cycle reset mid-line
        @(negedge clk25);
        drive_row(mk(3'b101, 0, 1, 0, 0, F5, 0, F5), "pre_rst");
        rst = 1'b1;
        @(negedge clk25);
        check("midrst_out", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, 32'h3);
        check("midrst_led", {31'd0, led_hb}, 32'd0);
        sb_q.delete();
        rst = 1'b0;
        drive_row(mk(3'b101, 0, 1, 0, 0, F5, 0, F5), "rel0");
        step(mk(3'b101, 0, 1, 0, 0, F5, 0,  F5), "rel1");
        step(mk(3'b101, 0, 1, 0, 0, F5, 0,  F5), "rel2");
        step(mk(3'b010, 1, 1, 0, 0, 0,  F6, 0),  "rel3");
        step(mk(3'b000, 1, 1, 0, 0, 0,  0,  0),  "rel4");
        step(mk(3'b000, 1, 1, 0, 0, 0,  0,  0),  "rel5");

        // Two-bit input expansion on the second instance
        check("wide_a", {vga_r2, vga_g2, vga_b2}, {5'b10101, 6'b010101, 5'b11111});
        r2 = 2'b01; g2 = 2'b10; b2 = 2'b00;
        step(mk(3'b000, 1, 1, 0, 0, 0, 0, 0), "rel6");
        step(mk(3'b000, 1, 1, 0, 0, 0, 0, 0), "rel7");
        step(mk(3'b000, 1, 1, 0, 0, 0, 0, 0), "rel8");
        check("wide_b", {vga_r2, vga_g2, vga_b2}, {5'b01010, 6'b101010, 5'b00000});

        // vs already active at reset release counts as a frame edge
        @(negedge clk25);
        rst = 1'b1; vs_in = 1'b0; hs_in = 1'b1; mode = 2'd1;
        {r_in, g_in, b_in} = 3'b100;
        @(negedge clk25);
        sb_q.delete();
        rst = 1'b0;
        drive_row(mk(3'b100, 1, 0, 1, 0, F5, 0,  0), "vsrel0");
        step(mk(3'b100, 1, 0, 1, 0, 0,  F6, 0), "vsrel1");
        step(mk(3'b100, 1, 1, 1, 0, 0,  F6, 0), "vsrel2");
        step(mk(3'b000, 1, 1, 1, 0, 0,  0,  0), "vsrel3");
        step(mk(3'b000, 1, 1, 1, 0, 0,  0,  0), "vsrel4");
        step(mk(3'b000, 1, 1, 1, 0, 0,  0,  0), "vsrel5");

        // Heartbeat over 60 frames
        @(negedge clk25);
        rst = 1'b1; vs_in = 1'b1; hs_in = 1'b1; mode = 2'd0;
        @(negedge clk25);
        check("hb_reset", {31'd0, led_hb}, 32'd0);
        rst = 1'b0;
        for (int p = 1; p <= 60; p++) begin
            @(negedge clk25);
            vs_in = 1'b0;
            @(negedge clk25);
            vs_in = 1'b1;
            if (p == 29) check("hb_29", {31'd0, led_hb}, 32'd0);
            if (p == 30) check("hb_30", {31'd0, led_hb}, 32'd1);
            if (p == 59) check("hb_59", {31'd0, led_hb}, 32'd1);
            if (p == 60) check("hb_60", {31'd0, led_hb}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_out_stage.md
VGA_OUT_STAGE -- requirements
Module: vga_out_stage

Interface
REQ-001 Parameter IN_W, default 1, bits per input colour channel (1..8).
REQ-002 Parameter R_W, default 5, red output width; G_W, default 6, green output width; B_W, default 5, blue output width.
REQ-003 Parameter PIPE, default 2, pixel and sync latency in clk25 cycles (1..8).
REQ-004 Parameter SYNC_ACT_LOW, default 1, selects the sync polarity used on inputs and outputs (1 means active-low).
REQ-005 Parameter HB_FRAMES, default 30, number of frames per heartbeat LED toggle.
REQ-006 clk25  in  1  single clock; all logic is clocked on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 r_in, g_in, b_in  in  IN_W each  source pixel colour.
REQ-009 hs_in, vs_in  in  1 each  source syncs, with polarity set by SYNC_ACT_LOW.
REQ-010 mode  in  2  0 RGB, 1 mono-green, 2 mono-white, 3 blank.
REQ-011 scan_en  in  1  enables scanline dimming.
REQ-012 vga_r  out  R_W; vga_g  out  G_W; vga_b  out  B_W: expanded colour.
REQ-013 vga_hs, vga_vs  out  1 each  delayed syncs, same polarity as the inputs.
REQ-014 led_hb  out  1  frame heartbeat.

Function
REQ-015 The block SHALL delay colour and syncs by exactly PIPE cycles, so input sample n appears on the outputs at cycle n+PIPE with syncs and pixels aligned.
REQ-016 Expansion SHALL replicate the input bits MSB-first and truncate to the output width, e.g. IN_W=2 value "10" gives "10101" on 5 bits; when IN_W exceeds the output width, the block SHALL keep the input MSBs.
REQ-017 Mode 0 SHALL output the expanded r/g/b values.
REQ-018 Mode 1 SHALL set "on" = OR of the three input MSBs; when on, the block SHALL drive G all-ones and R=B=0, otherwise all zero.
REQ-019 Mode 2 SHALL use the same "on" definition and drive all channels all-ones when on, otherwise all zero.
REQ-020 Mode 3 SHALL force all colour outputs to 0, with syncs still passing through.
REQ-021 The active hs edge SHALL be the inactive->active transition of hs_in detected against its previous sample; the active vs edge SHALL be defined the same way.
REQ-022 The line-parity bit SHALL toggle on each active hs edge and clear to 0 on each active vs edge; when both edges occur in the same cycle, vs wins and parity becomes 0.
REQ-023 An updated parity value SHALL take effect for pixels sampled from the cycle after the edge cycle onward.
REQ-024 When the effective scan_en is 1 and parity is 1, the block SHALL shift each output channel right by 1 bit (halving it) after the mode logic.
REQ-025 mode and scan_en SHALL be latched into effective registers only on an active vs edge, and the latched values SHALL apply from the next cycle; mid-frame changes SHALL have no visible effect.
REQ-026 A frame counter (ceil(log2 HB_FRAMES) bits) SHALL increment on each active vs edge; on reaching HB_FRAMES-1 it SHALL wrap to 0 and toggle led_hb.

Reset
REQ-027 While rst=1, the block SHALL drive vga_r/g/b=0, vga_hs/vga_vs to the inactive level (1 when SYNC_ACT_LOW=1), and led_hb=0.
REQ-028 Reset SHALL clear the delay line to inactive syncs and zero colour, set parity to 0 and the frame counter to 0, set the effective mode to 0, and set the effective scan_en to 0.
REQ-029 The previous-sync registers SHALL reset to the inactive level, so that an input already active at reset release counts as an edge on the first cycle.
REQ-030 Reset asserted mid-frame SHALL take effect on the next clock edge, and the block SHALL discard all in-flight pipeline data.

Structure
REQ-031 Package vga_out_pkg SHALL hold the mode enum (MODE_RGB, MODE_MONO_G, MODE_MONO_W, MODE_BLANK) and the default width constants.
REQ-032 The PIPE-stage shift register SHALL be a sub-module named vga_delay_line, parametrised by data width and depth, with a synchronous reset value input.
REQ-033 The expansion SHALL be a pure function in vga_out_pkg, with no extra pipeline stage beyond PIPE.

Verification
REQ-034 Scenario: defaults, mode 0, r_in=1 g_in=0 b_in=1 held -> after 2 cycles vga_r=11111, vga_g=000000, vga_b=11111, syncs delayed 2 cycles.
REQ-035 Scenario: IN_W=2, r_in=10, g_in=01 -> vga_r=10101, vga_g=010101.
REQ-036 Scenario: mode changed 0->1 mid-frame -> output unchanged until the next vs falling edge; from then on, a pixel with any channel on gives G=111111 and R=B=0.
REQ-037 Scenario: scan_en=1 latched, mode 2, pixels on -> even lines give 11111/111111/11111, odd lines give 01111/011111/01111; hs and vs asserted in the same cycle -> next line is even.
REQ-038 Scenario: 60 vs pulses with HB_FRAMES=30 -> led_hb toggles at frames 30 and 60 and ends at 0.
REQ-039 Scenario: rst pulsed for 1 cycle mid-line -> next cycle colour=0 and syncs inactive; PIPE cycles after release, outputs track the input again.
